dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning storage size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access fault flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid && req_ready at edge E, SHALL latch we/size/unsigned/addr/wdata, load counter with LATENCY-1, enter WAIT.
REQ-018 WAIT: counter decrements each cycle; at the edge where counter == 0 SHALL perform the access, register the result, enter RESP; rsp_valid therefore rises at edge E+LATENCY.
REQ-019 RESP: rsp_valid/rsp_rdata/rsp_err SHALL hold stable until rsp_valid && rsp_ready, then return to IDLE; a new request is accepted no earlier than the cycle after the handshake.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around, no fault).
REQ-021 Stores SHALL write only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all four); other lanes unchanged.
REQ-022 Loads SHALL select the addressed lane(s), shift to bit 0, and sign- or zero-extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-023 A load issued after a store completes SHALL return the stored data (no stale read).
REQ-024 req_valid while not in IDLE SHALL be ignored; request inputs are sampled only at the accepting edge.

Reset
REQ-025 Asserting rst_n low at any time SHALL immediately force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
REQ-026 Reset mid-WAIT SHALL drop the pending access; a store not yet committed SHALL NOT modify storage.
REQ-027 Storage array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN SHALL enable access fault detection.
REQ-029 With DMEM_ALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or req_size=11 SHALL complete with rsp_err=1, rsp_rdata=0, no storage write, same latency.
REQ-030 Without DMEM_ALIGN_CHECK_EN: rsp_err SHALL be constant 0, half ignores addr[0], word ignores addr[1:0], req_size=11 behaves as word.

Verification
REQ-031 Word store addr 0x10 data 0xDEADBEEF, then word load addr 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid rises exactly LATENCY cycles after each acceptance.
REQ-032 Byte store 0x80 to addr 0x13 over 0x00000000, then byte load signed -> 0xFFFFFF80, byte load unsigned -> 0x00000080, word load -> 0x80000000.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored; handshake then returns to IDLE.
REQ-034 Half store addr 0x21 data 0x1234 -> with DMEM_ALIGN_CHECK_EN: rsp_err=1, word at 0x20 unchanged; without: rsp_err=0, word at 0x20 = 0x00001234.
REQ-035 Store 0xCAFEF00D to addr 0x40 with LATENCY=4, pulse rst_n low in WAIT -> outputs at reset values, later load of 0x40 returns prior contents.
REQ-036 DEPTH=16: store to addr 0x44 then load addr 0x04 -> same data (wrap-around).

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller with a fixed request-to-response
// latency, byte/half/word access and sign/zero extension of load data.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned half/word
// accesses and the reserved size encoding as faults. Faulted accesses never write storage.
module dmem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic          we_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   mem_r [DEPTH];

  logic          accept_s;
  logic          commit_s;
  logic          handshake_s;
  logic          fault_s;
  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic [31:0]   rword_s;
  logic [31:0]   rbyte_shift_s;
  logic [31:0]   rhalf_shift_s;
  logic [31:0]   load_data_s;

  assign accept_s    = (state_r == IDLE) && req_valid;
  assign commit_s    = (state_r == WAIT) && (cnt_r == {CW{1'b0}});
  assign handshake_s = (state_r == RESP) && rsp_ready;
  assign idx_s       = addr_r[AW+1:2];
  assign rword_s     = mem_r[idx_s];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = WAIT;
        else          state_next_s = IDLE;
      end
      WAIT: begin
        if (commit_s) state_next_s = RESP;
        else          state_next_s = WAIT;
      end
      RESP: begin
        if (handshake_s) state_next_s = IDLE;
        else             state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Request handshake output, decoded from the state register only.
  always_comb begin
    req_ready = (state_r == IDLE);
  end

  // Latency counter: loaded on acceptance, counts down to the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= CW'(LATENCY - 1);
    end else if ((state_r == WAIT) && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Request fields are captured only at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= req_we;
      size_r  <= req_size;
      uns_r   <= req_unsigned;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Fault on misaligned half/word or the reserved size encoding.
  always_comb begin
    fault_s = 1'b0;
    case (size_r)
      2'b00:   fault_s = 1'b0;
      2'b01:   fault_s = addr_r[0];
      2'b10:   fault_s = |addr_r[1:0];
      default: fault_s = 1'b1;
    endcase
  end
`else
  // Without checking, no access can fault.
  always_comb begin
    fault_s = 1'b0;
  end
`endif

  // Byte-lane enables and lane-replicated write data; reserved size acts as word.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = 32'h0000_0000;
    case (size_r)
      2'b00: begin
        be_s    = 4'b0001 << addr_r[1:0];
        wlane_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_r[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wlane_s = wdata_r;
      end
    endcase
  end

  // Load alignment and extension; stores and faults return zero.
  always_comb begin
    load_data_s   = 32'h0000_0000;
    rbyte_shift_s = rword_s >> {addr_r[1:0], 3'b000};
    rhalf_shift_s = rword_s >> {addr_r[1], 4'b0000};
    if (we_r || fault_s) begin
      load_data_s = 32'h0000_0000;
    end else begin
      case (size_r)
        2'b00:   load_data_s = {{24{~uns_r & rbyte_shift_s[7]}}, rbyte_shift_s[7:0]};
        2'b01:   load_data_s = {{16{~uns_r & rhalf_shift_s[15]}}, rhalf_shift_s[15:0]};
        default: load_data_s = rword_s;
      endcase
    end
  end

  // Storage write at the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && we_r && !fault_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
      end
    end
  end

  // Response registers: set at commit, held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (commit_s) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_data_s;
      rsp_err   <= fault_s;
    end else if (handshake_s) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
